// File: rtl/slv_i2c_reg_ctrl_if.sv
// rtl/slv_i2c_reg_ctrl_if.sv - I2C slave FSM to register controller handshake bundle
interface slv_i2c_reg_ctrl_if #(
    parameter int DATA_SZ = 8,
    parameter int REG_NUM = 16
);
    logic                       I_ADDR_VLD;
    logic [DATA_SZ-2:0]         I_ADDR_SLV;
    logic                       I_RW;
    logic                       I_BYTE_VLD;
    logic [DATA_SZ-1:0]         I_DATA_RD;
    logic                       I_MACK_VLD;
    logic                       I_ACK_MSTR;
    logic                       I_STOP;
    logic                       O_ACK;
    logic [DATA_SZ-1:0]         O_DATA_WR;
    logic                       O_WR_STB;
    logic [$clog2(REG_NUM)-1:0] O_REG_IDX;

    modport master (
        output I_ADDR_VLD, I_ADDR_SLV, I_RW, I_BYTE_VLD, I_DATA_RD,
               I_MACK_VLD, I_ACK_MSTR, I_STOP,
        input  O_ACK, O_DATA_WR, O_WR_STB, O_REG_IDX
    );

    modport slave (
        input  I_ADDR_VLD, I_ADDR_SLV, I_RW, I_BYTE_VLD, I_DATA_RD,
               I_MACK_VLD, I_ACK_MSTR, I_STOP,
        output O_ACK, O_DATA_WR, O_WR_STB, O_REG_IDX
    );
endinterface

// File: rtl/slv_i2c_reg_ctrl.sv
// rtl/slv_i2c_reg_ctrl.sv - I2C slave register file controller with host port
// Optional pointer auto-increment: define SLV_I2C_REG_CTRL_AUTOINC_EN.
module slv_i2c_reg_ctrl #(
    parameter int                 DATA_SZ  = 8,
    parameter logic [DATA_SZ-2:0] SLV_ADDR = 7'h42,
    parameter int                 REG_NUM  = 16
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    slv_i2c_reg_ctrl_if.slave          bus,
    input  logic                       I_HOST_WE,
    input  logic [$clog2(REG_NUM)-1:0] I_HOST_ADDR,
    input  logic [DATA_SZ-1:0]         I_HOST_DATA,
    output logic [DATA_SZ-1:0]         O_HOST_DATA
);
    localparam int IDX_W = $clog2(REG_NUM);
    localparam logic [DATA_SZ-1:0] REG_NUM_B = DATA_SZ'(REG_NUM);
`ifdef SLV_I2C_REG_CTRL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PTR,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic               ack_q, ack_nxt;
    logic               bus_we;
    logic               data_ld;
    logic [DATA_SZ-1:0] regs [REG_NUM];
    logic [DATA_SZ-1:0] data_wr_q;
    logic               wr_stb_q;
    logic [IDX_W-1:0]   wr_idx_q;
    logic [DATA_SZ-1:0] host_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack_nxt   = ack_q;
        ptr_nxt   = ptr;
        bus_we    = 1'b0;
        data_ld   = 1'b0;
        case (state)
            ST_PTR: begin
                if (bus.I_BYTE_VLD) begin
                    if (bus.I_DATA_RD < REG_NUM_B) begin
                        ptr_nxt   = bus.I_DATA_RD[IDX_W-1:0];
                        ack_nxt   = 1'b0;
                        state_nxt = ST_WR_DATA;
                    end else begin
                        ack_nxt   = 1'b1;
                        state_nxt = ST_IGNORE;
                    end
                end
            end
            ST_WR_DATA: begin
                if (bus.I_BYTE_VLD) begin
                    bus_we  = 1'b1;
                    ack_nxt = 1'b0;
                    if (AUTOINC) begin
                        ptr_nxt = ptr + IDX_W'(1);
                    end
                end
            end
            ST_RD_DATA: begin
                if (bus.I_MACK_VLD) begin
                    if (!bus.I_ACK_MSTR) begin
                        data_ld = 1'b1;
                        if (AUTOINC) begin
                            ptr_nxt = ptr + IDX_W'(1);
                        end
                    end else begin
                        ack_nxt   = 1'b1;
                        state_nxt = ST_IGNORE;
                    end
                end
            end
            default: begin
                ack_nxt = 1'b1;
            end
        endcase

        // A byte arriving with STOP still lands; only the state is overridden.
        if (bus.I_STOP) begin
            state_nxt = ST_IDLE;
            ack_nxt   = 1'b1;
        end

        // A new command supersedes anything else seen in the same cycle.
        if (bus.I_ADDR_VLD) begin
            bus_we  = 1'b0;
            ptr_nxt = ptr;
            if (bus.I_ADDR_SLV == SLV_ADDR) begin
                ack_nxt   = 1'b0;
                state_nxt = bus.I_RW ? ST_RD_DATA : ST_PTR;
                data_ld   = bus.I_RW;
            end else begin
                ack_nxt   = 1'b1;
                data_ld   = 1'b0;
                state_nxt = ST_IGNORE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ptr       <= '0;
            ack_q     <= 1'b1;
            data_wr_q <= '0;
            wr_stb_q  <= 1'b0;
            wr_idx_q  <= '0;
            host_q    <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            ptr      <= ptr_nxt;
            ack_q    <= ack_nxt;
            wr_stb_q <= bus_we;
            host_q   <= regs[I_HOST_ADDR];
            if (bus_we) begin
                wr_idx_q  <= ptr;
                regs[ptr] <= bus.I_DATA_RD;
            end
            if (I_HOST_WE && !(bus_we && (ptr == I_HOST_ADDR))) begin
                regs[I_HOST_ADDR] <= I_HOST_DATA;
            end
            if (data_ld) begin
                data_wr_q <= regs[ptr_nxt];
            end
        end
    end

    // During a write strobe the index shows the register just written.
    assign bus.O_REG_IDX = wr_stb_q ? wr_idx_q : ptr;
    assign bus.O_ACK     = ack_q;
    assign bus.O_DATA_WR = data_wr_q;
    assign bus.O_WR_STB  = wr_stb_q;
    assign O_HOST_DATA   = host_q;
endmodule

// File: tb/tb_slv_i2c_reg_ctrl.sv
// tb/tb_slv_i2c_reg_ctrl.sv - randomized self-checking bench for slv_i2c_reg_ctrl
module tb_slv_i2c_reg_ctrl;
    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [16];
    int         m_ptr;
    int         inc;
    logic [7:0] wq [$];

    always #10 CLK = ~CLK;

    slv_i2c_reg_ctrl_if #(.DATA_SZ(8), .REG_NUM(16)) bus ();

    slv_i2c_reg_ctrl #(.DATA_SZ(8), .SLV_ADDR(7'h42), .REG_NUM(16)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .bus        (bus),
        .I_HOST_WE  (host_we),
        .I_HOST_ADDR(host_addr),
        .I_HOST_DATA(host_wdata),
        .O_HOST_DATA(host_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_quiet();
        bus.I_ADDR_VLD = 1'b0;
        bus.I_ADDR_SLV = '0;
        bus.I_RW       = 1'b0;
        bus.I_BYTE_VLD = 1'b0;
        bus.I_DATA_RD  = '0;
        bus.I_MACK_VLD = 1'b0;
        bus.I_ACK_MSTR = 1'b0;
        bus.I_STOP     = 1'b0;
    endtask

    task automatic send_stop();
        bus.I_STOP = 1'b1;
        step();
        bus.I_STOP = 1'b0;
        chk("stop_ack", bus.O_ACK, 1);
        chk("stop_ptr", bus.O_REG_IDX, m_ptr);
    endtask

    // Whole write transaction: address, pointer byte, then the bytes queued in wq.
    task automatic write_txn(input logic [6:0] a, input logic [7:0] p);
        bit ok;
        ok = (a == 7'h42);
        bus.I_ADDR_VLD = 1'b1; bus.I_ADDR_SLV = a; bus.I_RW = 1'b0;
        step();
        bus.I_ADDR_VLD = 1'b0;
        chk("wr_addr_ack", bus.O_ACK, !ok);
        bus.I_BYTE_VLD = 1'b1; bus.I_DATA_RD = p;
        step();
        bus.I_BYTE_VLD = 1'b0;
        if (ok && p < 16) m_ptr = p;
        else ok = 0;
        chk("ptr_ack", bus.O_ACK, !ok);
        chk("ptr_stb", bus.O_WR_STB, 0);
        foreach (wq[i]) begin
            bus.I_BYTE_VLD = 1'b1; bus.I_DATA_RD = wq[i];
            step();
            bus.I_BYTE_VLD = 1'b0;
            if (ok) begin
                chk("wr_stb", bus.O_WR_STB, 1);
                chk("wr_idx", bus.O_REG_IDX, m_ptr);
                chk("wr_ack", bus.O_ACK, 0);
                mem[m_ptr] = wq[i];
                m_ptr = (m_ptr + inc) % 16;
            end else begin
                chk("ign_stb", bus.O_WR_STB, 0);
                chk("ign_ack", bus.O_ACK, 1);
            end
        end
        wq.delete();
        send_stop();
    endtask

    // Read transaction: n master ACKs followed by a NACK.
    task automatic read_txn(input logic [6:0] a, input int n);
        bit ok;
        ok = (a == 7'h42);
        bus.I_ADDR_VLD = 1'b1; bus.I_ADDR_SLV = a; bus.I_RW = 1'b1;
        step();
        bus.I_ADDR_VLD = 1'b0;
        chk("rd_addr_ack", bus.O_ACK, !ok);
        if (ok) chk("rd_first", bus.O_DATA_WR, mem[m_ptr]);
        for (int i = 0; i < n; i++) begin
            bus.I_MACK_VLD = 1'b1; bus.I_ACK_MSTR = 1'b0;
            step();
            bus.I_MACK_VLD = 1'b0;
            if (ok) begin
                m_ptr = (m_ptr + inc) % 16;
                chk("rd_next", bus.O_DATA_WR, mem[m_ptr]);
                chk("rd_ack", bus.O_ACK, 0);
            end
        end
        bus.I_MACK_VLD = 1'b1; bus.I_ACK_MSTR = 1'b1;
        step();
        bus.I_MACK_VLD = 1'b0; bus.I_ACK_MSTR = 1'b0;
        chk("nack_ack", bus.O_ACK, 1);
        if (ok) chk("nack_hold", bus.O_DATA_WR, mem[m_ptr]);
        chk("nack_ptr", bus.O_REG_IDX, m_ptr);
        send_stop();
    endtask

    task automatic host_write(input int idx, input logic [7:0] d);
        host_we = 1'b1; host_addr = 4'(idx); host_wdata = d;
        step();
        host_we = 1'b0;
        mem[idx] = d;
    endtask

    task automatic host_read(input int idx, output logic [7:0] d);
        host_addr = 4'(idx);
        step();
        d = host_rdata;
    endtask

    task automatic check_regs();
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            host_read(i, d);
            chk($sformatf("reg%0d", i), d, mem[i]);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [6:0] a;
        logic [7:0] p;
        int         n;
`ifdef SLV_I2C_REG_CTRL_AUTOINC_EN
        inc = 1;
`else
        inc = 0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        m_ptr = 0;
        bus_quiet();
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) step();
        chk("rst_ack", bus.O_ACK, 1);
        chk("rst_data", bus.O_DATA_WR, 0);
        chk("rst_stb", bus.O_WR_STB, 0);
        chk("rst_host", host_rdata, 0);
        chk("rst_idx", bus.O_REG_IDX, 0);
        RST_n = 1'b1;
        step();

        wq.push_back(8'hA5); wq.push_back(8'h5A);
        write_txn(7'h42, 8'h03);
        host_read(3, d);
        chk("basic_reg3", d, inc ? 8'hA5 : 8'h5A);
        host_read(4, d);
        chk("basic_reg4", d, inc ? 8'h5A : 8'h00);

        for (int i = 0; i < 16; i++) host_write(i, 8'(i * 17 + 3));
        write_txn(7'h42, 8'h0F);
        read_txn(7'h42, 2);
        chk("wrap_ptr", bus.O_REG_IDX, inc ? 1 : 15);

        wq.push_back(8'hFF);
        write_txn(7'h13, 8'hFF);
        wq.push_back(8'h99);
        write_txn(7'h42, 8'h20);

        // Bus and host write the same register in the same cycle.
        bus.I_ADDR_VLD = 1'b1; bus.I_ADDR_SLV = 7'h42; bus.I_RW = 1'b0;
        step();
        bus.I_ADDR_VLD = 1'b0;
        bus.I_BYTE_VLD = 1'b1; bus.I_DATA_RD = 8'h02;
        step();
        bus.I_DATA_RD = 8'h22;
        host_we = 1'b1; host_addr = 4'd2; host_wdata = 8'h11;
        step();
        bus.I_BYTE_VLD = 1'b0; host_we = 1'b0;
        chk("coll_stb", bus.O_WR_STB, 1);
        step();
        chk("coll_host", host_rdata, 8'h22);
        mem[2] = 8'h22;
        m_ptr = (2 + inc) % 16;
        send_stop();

        // Address with STOP: address wins; byte with STOP: byte lands, then idle.
        bus.I_ADDR_VLD = 1'b1; bus.I_ADDR_SLV = 7'h42; bus.I_RW = 1'b0; bus.I_STOP = 1'b1;
        step();
        bus.I_ADDR_VLD = 1'b0; bus.I_STOP = 1'b0;
        chk("addr_stop_ack", bus.O_ACK, 0);
        bus.I_BYTE_VLD = 1'b1; bus.I_DATA_RD = 8'h05;
        step();
        chk("addr_stop_ptr", bus.O_ACK, 0);
        m_ptr = 5;
        bus.I_DATA_RD = 8'h77; bus.I_STOP = 1'b1;
        step();
        bus.I_STOP = 1'b0;
        chk("byte_stop_stb", bus.O_WR_STB, 1);
        chk("byte_stop_idx", bus.O_REG_IDX, 5);
        chk("byte_stop_ack", bus.O_ACK, 1);
        mem[5] = 8'h77;
        m_ptr = (5 + inc) % 16;
        bus.I_DATA_RD = 8'h66;
        step();
        bus.I_BYTE_VLD = 1'b0;
        chk("idle_byte_stb", bus.O_WR_STB, 0);
        check_regs();

        repeat (40) begin
            case ($urandom_range(0, 3))
                0: host_write($urandom_range(0, 15), 8'($urandom));
                1: begin
                    a = ($urandom_range(0, 4) == 0) ? 7'h13 : 7'h42;
                    p = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
                    n = $urandom_range(0, 4);
                    for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
                    write_txn(a, p);
                end
                default: begin
                    a = ($urandom_range(0, 4) == 0) ? 7'h21 : 7'h42;
                    read_txn(a, $urandom_range(0, 3));
                end
            endcase
        end
        check_regs();

        // Reset between two data bytes abandons the transaction.
        bus.I_ADDR_VLD = 1'b1; bus.I_ADDR_SLV = 7'h42; bus.I_RW = 1'b0;
        step();
        bus.I_ADDR_VLD = 1'b0;
        bus.I_BYTE_VLD = 1'b1; bus.I_DATA_RD = 8'h03;
        step();
        bus.I_DATA_RD = 8'hA5;
        step();
        bus.I_BYTE_VLD = 1'b0;
        RST_n = 1'b0;
        #1;
        chk("mid_rst_ack", bus.O_ACK, 1);
        chk("mid_rst_data", bus.O_DATA_WR, 0);
        chk("mid_rst_stb", bus.O_WR_STB, 0);
        chk("mid_rst_host", host_rdata, 0);
        chk("mid_rst_idx", bus.O_REG_IDX, 0);
        step();
        RST_n = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        m_ptr = 0;
        bus.I_BYTE_VLD = 1'b1; bus.I_DATA_RD = 8'h5A;
        step();
        bus.I_BYTE_VLD = 1'b0;
        chk("post_rst_stb", bus.O_WR_STB, 0);
        chk("post_rst_ack", bus.O_ACK, 1);
        check_regs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
